// File: rtl/toggle_cover_pkg.sv
// toggle_cover_pkg: shared state encoding and index width for the toggle cover scheduler
package toggle_cover_pkg;
  localparam int COVER_IDX_W = 64;
  typedef enum logic [1:0] {IDLE, PRESENT, CLR_WAIT, CLR} state_e;
endpackage

// File: rtl/toggle_cover_prio_enc.sv
// toggle_cover_prio_enc: combinational lowest-set-bit encoder
module toggle_cover_prio_enc #(
  parameter  int WIDTH = 28,
  localparam int IW    = WIDTH > 1 ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] vec_i,
  output logic             any_o,
  output logic [IW-1:0]    idx_o
);
  always_comb begin
    any_o = |vec_i;
    idx_o = '0;
    for (int i = WIDTH - 1; i >= 0; i--) if (vec_i[i]) idx_o = IW'(i);
  end
endmodule

// File: rtl/toggle_cover_scheduler.sv
// toggle_cover_scheduler: dedups toggle hits and serialises first hits as global indices
module toggle_cover_scheduler
  import toggle_cover_pkg::*;
#(
  parameter  int WIDTH       = 28,
  parameter  int COVER_INDEX = 0,
  parameter  int COVER_TOTAL = 8940,
  localparam int IW          = WIDTH > 1 ? $clog2(WIDTH) : 1,
  localparam int CW          = $clog2(WIDTH + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   en_i,
  input  logic [WIDTH-1:0]       valid_i,
  input  logic                   clear_i,
  input  logic                   out_ready_i,
  output logic                   out_valid_o,
  output logic [COVER_IDX_W-1:0] out_index_o,
  output logic [CW-1:0]          hit_count_o,
  output logic                   all_covered_o,
  output logic                   clear_busy_o
);
  if (WIDTH < 1 || WIDTH > 64 || COVER_INDEX + WIDTH > COVER_TOTAL) begin : g_bad_cfg
    $error("toggle_cover_scheduler: bad WIDTH/COVER_INDEX/COVER_TOTAL");
  end
  state_e                 state_q, state_d;
  logic [WIDTH-1:0]       covered_q, covered_d, pending_q, pending_d, new_hits, rem;
  logic [IW-1:0]          cur_q, cur_d, enc_idx;
  logic [COVER_IDX_W-1:0] out_index_q, out_index_d;
  logic [CW-1:0]          hit_q, hit_d, pop;
  logic                   enc_any, capture, xfer;
  assign capture       = en_i && (state_q == IDLE || state_q == PRESENT);
  assign new_hits      = capture ? valid_i & ~covered_q : '0;
  assign rem           = pending_q & ~(WIDTH'(1) << cur_q);
  assign out_valid_o   = state_q == PRESENT || state_q == CLR_WAIT;
  assign xfer          = out_valid_o && out_ready_i;
  assign clear_busy_o  = state_q == CLR_WAIT || state_q == CLR;
  assign out_index_o   = out_index_q;
  assign hit_count_o   = hit_q;
  assign all_covered_o = hit_q == CW'(WIDTH);
  // IDLE picks from the registered pending set; a presenting state picks the successor
  toggle_cover_prio_enc #(.WIDTH(WIDTH)) u_enc (
    .vec_i(state_q == IDLE ? pending_q : rem),
    .any_o(enc_any),
    .idx_o(enc_idx)
  );
  always_comb begin
    pop = '0;
    for (int i = 0; i < WIDTH; i++) pop += CW'(new_hits[i]);
  end
  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    out_index_d = out_index_q;
    covered_d   = covered_q | new_hits;
    pending_d   = (xfer ? rem : pending_q) | new_hits;
    hit_d       = hit_q + pop;
    unique case (state_q)
      IDLE:     state_d = clear_i ? CLR : enc_any ? PRESENT : IDLE;
      PRESENT:  state_d = xfer ? (enc_any ? (clear_i ? CLR_WAIT : PRESENT) : (clear_i ? CLR : IDLE))
                               : (clear_i ? CLR_WAIT : PRESENT);
      CLR_WAIT: state_d = xfer && !enc_any ? CLR : CLR_WAIT;
      default: begin
        state_d   = IDLE;
        covered_d = '0;
        pending_d = '0;
        hit_d     = '0;
      end
    endcase
    if (enc_any && ((state_q == IDLE && !clear_i) || xfer)) begin
      cur_d       = enc_idx;
      out_index_d = COVER_IDX_W'(COVER_INDEX) + COVER_IDX_W'(enc_idx);
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      covered_q   <= '0;
      pending_q   <= '0;
      cur_q       <= '0;
      out_index_q <= '0;
      hit_q       <= '0;
    end else begin
      state_q     <= state_d;
      covered_q   <= covered_d;
      pending_q   <= pending_d;
      cur_q       <= cur_d;
      out_index_q <= out_index_d;
      hit_q       <= hit_d;
    end
  end
endmodule

// File: tb/tb_toggle_cover_scheduler.sv
// tb_toggle_cover_scheduler: scoreboard bench for toggle_cover_scheduler
module tb_toggle_cover_scheduler;
  localparam int W  = 28;
  localparam int CI = 100;
  logic          clk = 0, rst_n = 0, en = 0, clear = 0, out_ready = 0;
  logic [W-1:0]  valid = '0;
  logic          out_valid, all_covered, clear_busy;
  logic [63:0]   out_index;
  logic [4:0]    hit_count;
  int            checks = 0, errors = 0;
  logic [63:0]   exp_q[$];
  logic [W-1:0]  cov_m = '0;

  toggle_cover_scheduler #(.WIDTH(W), .COVER_INDEX(CI), .COVER_TOTAL(8940)) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .valid_i(valid), .clear_i(clear),
    .out_ready_i(out_ready), .out_valid_o(out_valid), .out_index_o(out_index),
    .hit_count_o(hit_count), .all_covered_o(all_covered), .clear_busy_o(clear_busy)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk)
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("extra_beat", 64'(exp_q.size()), 64'd1);
      else check("beat_index", out_index, exp_q.pop_front());
    end

  task automatic hit(logic [W-1:0] v);
    valid = v;
    en    = 1;
    for (int i = 0; i < W; i++) if (v[i] && !cov_m[i]) exp_q.push_back(64'(CI + i));
    cov_m |= v;
    @(posedge clk); #1;
    valid = '0;
    en    = 0;
  endtask

  task automatic step(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain(int budget);
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < budget) begin
      step(1);
      n++;
    end
    check("drain_pending", 64'(exp_q.size()), 64'd0);
    check("drain_idle", 64'(out_valid), 64'd0);
  endtask

  initial begin
    step(2);
    check("rst_valid", 64'(out_valid), 0);
    check("rst_index", out_index, 0);
    check("rst_count", 64'(hit_count), 0);
    check("rst_allcov", 64'(all_covered), 0);
    check("rst_busy", 64'(clear_busy), 0);
    rst_n = 1;
    step(1);
    out_ready = 1;
    // two hits in one sample, reported lowest first on consecutive cycles
    hit(W'(5));
    check("t1_latency", 64'(out_valid), 0);
    step(1);
    check("t1_valid0", 64'(out_valid), 1);
    check("t1_idx0", out_index, 64'(CI));
    step(1);
    check("t1_valid1", 64'(out_valid), 1);
    check("t1_idx1", out_index, 64'(CI + 2));
    drain(10);
    check("t1_count", 64'(hit_count), 2);
    step(3);
    // a held level yields a single beat
    valid = W'(8);
    en    = 1;
    exp_q.push_back(64'(CI + 3));
    cov_m[3] = 1'b1;
    step(10);
    valid = '0;
    en    = 0;
    drain(10);
    check("t2_count", 64'(hit_count), 3);
    // back-pressure keeps the presented index stable
    out_ready = 0;
    hit(W'('h12));
    step(1);
    for (int i = 0; i < 5; i++) begin
      check("t3_hold_valid", 64'(out_valid), 1);
      check("t3_hold_idx", out_index, 64'(CI + 1));
      step(1);
    end
    out_ready = 1;
    drain(10);
    check("t3_count", 64'(hit_count), 5);
    // fresh reset, then every point at once
    rst_n = 0;
    exp_q.delete();
    cov_m = '0;
    step(2);
    rst_n = 1;
    step(1);
    hit('1);
    step(1);
    for (int i = 0; i < W; i++) begin
      check("t4_b2b_valid", 64'(out_valid), 1);
      step(1);
    end
    check("t4_done_valid", 64'(out_valid), 0);
    check("t4_pending", 64'(exp_q.size()), 0);
    check("t4_count", 64'(hit_count), 28);
    check("t4_allcov", 64'(all_covered), 1);
    hit(W'(1));
    step(3);
    check("t4_allcov_hold", 64'(all_covered), 1);
    check("t4_no_repeat", 64'(out_valid), 0);
    // clear from idle, then clear while presenting under back-pressure
    clear = 1;
    step(1);
    clear = 0;
    step(1);
    cov_m = '0;
    check("t5_count_idle_clr", 64'(hit_count), 0);
    check("t5_allcov_clr", 64'(all_covered), 0);
    out_ready = 0;
    hit(W'((1 << 5) | (1 << 9)));
    step(1);
    check("t5_present_idx", out_index, 64'(CI + 5));
    clear = 1;
    step(1);
    clear = 0;
    check("t5_busy", 64'(clear_busy), 1);
    valid = W'(1 << 7);
    en    = 1;
    step(1);
    valid = '0;
    en    = 0;
    check("t5_busy_hold", 64'(clear_busy), 1);
    check("t5_idx_hold", out_index, 64'(CI + 5));
    out_ready = 1;
    drain(10);
    check("t5_clr_state", 64'(clear_busy), 1);
    step(1);
    check("t5_busy_done", 64'(clear_busy), 0);
    check("t5_count_zero", 64'(hit_count), 0);
    cov_m = '0;
    hit(W'(1 << 5));
    drain(10);
    check("t5_rehit_count", 64'(hit_count), 1);
    // asynchronous reset in the middle of a burst
    hit('1);
    step(4);
    check("t6_mid_burst", 64'(out_valid), 1);
    #1;
    rst_n = 0;
    exp_q.delete();
    cov_m = '0;
    #1;
    check("t6_async_valid", 64'(out_valid), 0);
    check("t6_async_index", out_index, 0);
    check("t6_async_count", 64'(hit_count), 0);
    check("t6_async_allcov", 64'(all_covered), 0);
    check("t6_async_busy", 64'(clear_busy), 0);
    step(2);
    rst_n = 1;
    step(6);
    check("t6_no_stale", 64'(out_valid), 0);
    hit(W'(1));
    drain(10);
    check("t6_count", 64'(hit_count), 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
